redmule_stream_addrgen: RTL and testbench

Three-dimensional strided address generator for one RedMulE streamer channel (X, W, Y source or Z sink). It consumes the per-channel `addressgen_ctrl` fields and `req_start` produced by the memory scheduler. It emits one word address per handshake toward the TCDM streamer, and returns the `ready_start` / `done` flags the scheduler uses to sequence its iteration counters.

---
 rtl/redmule_pkg.sv | 29 ++
 rtl/redmule_stream_addrgen_if.sv | 16 +
 rtl/redmule_stream_addrgen_dim_cnt.sv | 38 +++
 rtl/redmule_stream_addrgen.sv | 125 ++++++++++++
 tb/tb_redmule_stream_addrgen.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE streamer address generators.
package redmule_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  tot_len;
    logic [CNT_W-1:0]  d0_len;
    logic [ADDR_W-1:0] d0_stride;
    logic [CNT_W-1:0]  d1_len;
    logic [ADDR_W-1:0] d1_stride;
    logic [ADDR_W-1:0] d2_stride;
    logic [1:0]        dim_enable_1h;
  } addrgen_ctrl_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } addrgen_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } addrgen_state_e;

endpackage

// File: rtl/redmule_stream_addrgen_if.sv
// Link between the address generator and one dimension counter.
interface redmule_stream_addrgen_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 32
);
  logic          clear;
  logic          step;
  logic          wrap_en;
  logic [CW-1:0] len;
  logic [AW-1:0] stride;
  logic [AW-1:0] offs;
  logic          wrap;

  modport master (output clear, step, wrap_en, len, stride, input offs, wrap);
  modport slave  (input clear, step, wrap_en, len, stride, output offs, wrap);
endinterface

// File: rtl/redmule_stream_addrgen_dim_cnt.sv
// One address dimension: counter plus offset accumulator with wrap detection.
module redmule_addrgen_dim_cnt #(
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  redmule_stream_addrgen_if.slave  dim
);

  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_offs;
  logic [CW-1:0] w_len_eff;

  // A zero length behaves as a single-element dimension.
  assign w_len_eff = (dim.len == '0) ? CW'(1) : dim.len;
  assign dim.wrap  = dim.wrap_en && (r_cnt == (w_len_eff - CW'(1)));
  assign dim.offs  = r_offs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_offs <= '0;
    end else if (dim.clear) begin
      r_cnt  <= '0;
      r_offs <= '0;
    end else if (dim.step) begin
      if (dim.wrap) begin
        r_cnt  <= '0;
        r_offs <= '0;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_offs <= r_offs + dim.stride;
      end
    end
  end

endmodule

// File: rtl/redmule_stream_addrgen.sv
// Three-dimensional strided address generator for one RedMulE streamer channel.
module redmule_stream_addrgen
  import redmule_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned CW = CNT_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          req_start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [CW-1:0] tot_len_i,
  input  logic [CW-1:0] d0_len_i,
  input  logic [AW-1:0] d0_stride_i,
  input  logic [CW-1:0] d1_len_i,
  input  logic [AW-1:0] d1_stride_i,
  input  logic [AW-1:0] d2_stride_i,
  input  logic [1:0]    dim_enable_1h_i,
  output logic          ready_start_o,
  output logic          done_o,
  output logic [AW-1:0] addr_o,
  output logic          addr_valid_o,
  input  logic          addr_ready_i
);

  addrgen_state_e r_state, w_state_nxt;
  addrgen_ctrl_t  r_ctrl;
  addrgen_flags_t r_flags;
  logic           r_valid;
  logic [CW-1:0]  r_tx_cnt;
  logic [AW-1:0]  r_d2_offs;

  logic w_start, w_hs, w_last, w_step;

  redmule_stream_addrgen_if #(.AW(AW), .CW(CW)) d0_if ();
  redmule_stream_addrgen_if #(.AW(AW), .CW(CW)) d1_if ();

  assign w_start = (r_state == ST_IDLE) && req_start_i && !clear_i;
  assign w_hs    = r_valid && addr_ready_i;
  assign w_last  = (r_tx_cnt == (r_ctrl.tot_len - CW'(1)));
  assign w_step  = w_hs && !w_last && !clear_i;

  // d1 only advances when d0 wraps; d2 only when both wrap.
  assign d0_if.clear   = clear_i || w_start;
  assign d0_if.step    = w_step;
  assign d0_if.wrap_en = r_ctrl.dim_enable_1h[0];
  assign d0_if.len     = r_ctrl.d0_len;
  assign d0_if.stride  = r_ctrl.d0_stride;

  assign d1_if.clear   = clear_i || w_start;
  assign d1_if.step    = w_step && d0_if.wrap;
  assign d1_if.wrap_en = r_ctrl.dim_enable_1h[1];
  assign d1_if.len     = r_ctrl.d1_len;
  assign d1_if.stride  = r_ctrl.d1_stride;

  redmule_addrgen_dim_cnt #(.AW(AW), .CW(CW)) i_d0_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .dim    (d0_if)
  );

  redmule_addrgen_dim_cnt #(.AW(AW), .CW(CW)) i_d1_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .dim    (d1_if)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (req_start_i) w_state_nxt = (tot_len_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_hs && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (clear_i) w_state_nxt = ST_IDLE;
  end

  // Flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state             <= ST_IDLE;
      r_flags.ready_start <= 1'b1;
      r_flags.done        <= 1'b0;
      r_valid             <= 1'b0;
    end else begin
      r_state             <= w_state_nxt;
      r_flags.ready_start <= (w_state_nxt == ST_IDLE);
      r_flags.done        <= (w_state_nxt == ST_DONE);
      r_valid             <= (w_state_nxt == ST_RUN);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl    <= '0;
      r_tx_cnt  <= '0;
      r_d2_offs <= '0;
    end else if (clear_i) begin
      r_tx_cnt  <= '0;
      r_d2_offs <= '0;
    end else if (w_start) begin
      r_ctrl.base_addr     <= base_addr_i;
      r_ctrl.tot_len       <= tot_len_i;
      r_ctrl.d0_len        <= d0_len_i;
      r_ctrl.d0_stride     <= d0_stride_i;
      r_ctrl.d1_len        <= d1_len_i;
      r_ctrl.d1_stride     <= d1_stride_i;
      r_ctrl.d2_stride     <= d2_stride_i;
      r_ctrl.dim_enable_1h <= dim_enable_1h_i;
      r_tx_cnt             <= '0;
      r_d2_offs            <= '0;
    end else begin
      if (w_hs) r_tx_cnt <= r_tx_cnt + CW'(1);
      if (d1_if.step && d1_if.wrap) r_d2_offs <= r_d2_offs + r_ctrl.d2_stride;
    end
  end

  assign addr_o        = r_ctrl.base_addr + r_d2_offs + d1_if.offs + d0_if.offs;
  assign addr_valid_o  = r_valid;
  assign ready_start_o = r_flags.ready_start;
  assign done_o        = r_flags.done;

endmodule

// File: tb/tb_redmule_stream_addrgen.sv
// Randomised self-checking bench for redmule_stream_addrgen against a closed-form address model.
module tb_redmule_stream_addrgen;
  import redmule_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i, req_start_i, addr_ready_i;
  logic [31:0] base_addr_i, tot_len_i, d0_len_i, d0_stride_i, d1_len_i, d1_stride_i, d2_stride_i;
  logic [1:0]  dim_enable_1h_i;
  logic        ready_start_o, done_o, addr_valid_o;
  logic [31:0] addr_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] obs_q[$];
  int          done_cyc, n_valid, unstable, last_hs_cyc;
  bit          timeout;
  logic        ready_at_done;

  always #5 clk_i = ~clk_i;

  redmule_stream_addrgen #(.AW(32), .CW(32)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .req_start_i     (req_start_i),
    .base_addr_i     (base_addr_i),
    .tot_len_i       (tot_len_i),
    .d0_len_i        (d0_len_i),
    .d0_stride_i     (d0_stride_i),
    .d1_len_i        (d1_len_i),
    .d1_stride_i     (d1_stride_i),
    .d2_stride_i     (d2_stride_i),
    .dim_enable_1h_i (dim_enable_1h_i),
    .ready_start_o   (ready_start_o),
    .done_o          (done_o),
    .addr_o          (addr_o),
    .addr_valid_o    (addr_valid_o),
    .addr_ready_i    (addr_ready_i)
  );

  // Address of element i as nested loops over (d2, d1, d0).
  function automatic logic [31:0] model_addr(input addrgen_ctrl_t c, input int unsigned i);
    int unsigned l0, l1, i0, j;
    l0 = (c.d0_len == 0) ? 1 : c.d0_len;
    l1 = (c.d1_len == 0) ? 1 : c.d1_len;
    if (!c.dim_enable_1h[0]) return c.base_addr + 32'(i) * c.d0_stride;
    i0 = i % l0;
    j  = i / l0;
    if (!c.dim_enable_1h[1]) return c.base_addr + 32'(i0) * c.d0_stride + 32'(j) * c.d1_stride;
    return c.base_addr + 32'(i0) * c.d0_stride + 32'(j % l1) * c.d1_stride
           + 32'(j / l1) * c.d2_stride;
  endfunction

  function automatic addrgen_ctrl_t basic_cfg();
    addrgen_ctrl_t c;
    c.base_addr = 32'h1000; c.tot_len = 8;
    c.d0_len = 2; c.d0_stride = 32'h4;
    c.d1_len = 2; c.d1_stride = 32'h40;
    c.d2_stride = 32'h200; c.dim_enable_1h = 2'b11;
    return c;
  endfunction

  task automatic drive_ctrl(input addrgen_ctrl_t c);
    base_addr_i = c.base_addr; tot_len_i = c.tot_len;
    d0_len_i = c.d0_len; d0_stride_i = c.d0_stride;
    d1_len_i = c.d1_len; d1_stride_i = c.d1_stride;
    d2_stride_i = c.d2_stride; dim_enable_1h_i = c.dim_enable_1h;
  endtask

  task automatic scramble_ctrl();
    base_addr_i = $urandom; tot_len_i = $urandom_range(30);
    d0_len_i = $urandom_range(5); d0_stride_i = $urandom;
    d1_len_i = $urandom_range(5); d1_stride_i = $urandom;
    d2_stride_i = $urandom; dim_enable_1h_i = 2'($urandom_range(3));
  endtask

  // Start one stream and record what the DUT emits; comparisons are made by the callers.
  task automatic collect(input addrgen_ctrl_t c, input int ready_pct, input int req_pulse_cyc);
    logic        prev_stall;
    logic [31:0] prev_addr;
    obs_q.delete();
    done_cyc = -1; n_valid = 0; unstable = 0; last_hs_cyc = -1; timeout = 0;
    ready_at_done = 1'bx;
    prev_stall = 1'b0; prev_addr = '0;
    @(negedge clk_i);
    drive_ctrl(c);
    req_start_i = 1'b1; addr_ready_i = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk_i);
      scramble_ctrl();
      req_start_i = (cyc == req_pulse_cyc);
      if (prev_stall && (!addr_valid_o || addr_o !== prev_addr)) unstable++;
      if (done_o) begin
        done_cyc = cyc; ready_at_done = ready_start_o;
        break;
      end
      if (addr_valid_o) n_valid++;
      addr_ready_i = ($urandom_range(99) < 32'(ready_pct));
      if (addr_valid_o && addr_ready_i) begin
        obs_q.push_back(addr_o); last_hs_cyc = cyc;
      end
      prev_stall = addr_valid_o && !addr_ready_i;
      prev_addr  = addr_o;
    end
    if (done_cyc < 0) timeout = 1;
    addr_ready_i = 1'b0; req_start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; req_start_i = 1'b0; addr_ready_i = 1'b0;
    drive_ctrl('0);
    repeat (2) @(negedge clk_i);
    checks++;
    if ({ready_start_o, done_o, addr_valid_o} !== 3'b100 || addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got rs/done/valid=%b addr=%h want 100 addr=00000000",
               {ready_start_o, done_o, addr_valid_o}, addr_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    logic [31:0] exp_a[8] = '{32'h1000, 32'h1004, 32'h1040, 32'h1044,
                              32'h1200, 32'h1204, 32'h1240, 32'h1244};
    collect(basic_cfg(), 100, 0);
    checks++;
    if (timeout || obs_q.size() != 8) begin
      errors++; $display("FAIL basic_count: got %0d handshakes (timeout=%0d) want 8", obs_q.size(), timeout);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_a[i]) begin
        errors++; $display("FAIL basic_addr[%0d]: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_a[i]);
      end
    end
    checks++;
    if (last_hs_cyc != 8 || done_cyc != 9) begin
      errors++; $display("FAIL basic_timing: got last_hs=%0d done=%0d want 8 and 9", last_hs_cyc, done_cyc);
    end
    checks++;
    if (ready_at_done !== 1'b0) begin
      errors++; $display("FAIL basic_ready_in_done: got %b want 0", ready_at_done);
    end
    @(negedge clk_i);
    checks++;
    if (ready_start_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL basic_back_idle: got rs=%b done=%b want 1 0", ready_start_o, done_o);
    end
  endtask

  task automatic test_xsrc();
    addrgen_ctrl_t c;
    c = basic_cfg();
    c.base_addr = 32'h2000; c.d0_len = 1; c.d0_stride = 0;
    c.d1_len = 4; c.d1_stride = 32'h60; c.tot_len = 4;
    collect(c, 100, 0);
    checks++;
    if (timeout || obs_q.size() != 4) begin
      errors++; $display("FAIL xsrc_count: got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== 32'h2000 + 32'(i) * 32'h60) begin
        errors++; $display("FAIL xsrc_addr[%0d]: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, 32'h2000 + 32'(i) * 32'h60);
      end
    end
  endtask

  task automatic test_backpressure();
    collect(basic_cfg(), 50, 0);
    checks++;
    if (timeout || obs_q.size() != 8 || unstable != 0) begin
      errors++; $display("FAIL bp_count: got %0d hs unstable=%0d want 8 hs unstable=0", obs_q.size(), unstable);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== model_addr(basic_cfg(), i)) begin
        errors++; $display("FAIL bp_addr[%0d]: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 32'hx, model_addr(basic_cfg(), i));
      end
    end
    checks++;
    if (done_cyc != last_hs_cyc + 1) begin
      errors++; $display("FAIL bp_done_timing: got done=%0d want %0d", done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_zero_len();
    addrgen_ctrl_t c;
    c = basic_cfg(); c.tot_len = 0;
    collect(c, 100, 0);
    checks++;
    if (done_cyc != 1 || n_valid != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL zero_len: got done=%0d valids=%0d want done=1 valids=0", done_cyc, n_valid);
    end
  endtask

  task automatic test_req_ignored();
    collect(basic_cfg(), 100, 3);
    checks++;
    if (timeout || obs_q.size() != 8) begin
      errors++; $display("FAIL req_run_count: got %0d want 8", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      checks++;
      if (obs_q[i] !== model_addr(basic_cfg(), i)) begin
        errors++; $display("FAIL req_run_addr[%0d]: got %h want %h", i, obs_q[i], model_addr(basic_cfg(), i));
      end
    end
    @(negedge clk_i);
    checks++;
    if (ready_start_o !== 1'b1 || addr_valid_o !== 1'b0) begin
      errors++; $display("FAIL req_run_idle: got rs=%b valid=%b want 1 0", ready_start_o, addr_valid_o);
    end
  endtask

  task automatic test_clear();
    int dones = 0;
    @(negedge clk_i);
    drive_ctrl(basic_cfg()); req_start_i = 1'b1;
    @(negedge clk_i);
    req_start_i = 1'b0; addr_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (addr_valid_o !== 1'b1 || addr_o !== 32'h1044) begin
      errors++; $display("FAIL clear_pre: got valid=%b addr=%h want 1 00001044", addr_valid_o, addr_o);
    end
    clear_i = 1'b1; addr_ready_i = 1'b0;
    @(negedge clk_i);
    clear_i = 1'b0;
    checks++;
    if (ready_start_o !== 1'b1 || addr_valid_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL clear_idle: got rs=%b valid=%b done=%b want 1 0 0", ready_start_o, addr_valid_o, done_o);
    end
    repeat (4) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL clear_no_done: got %0d done pulses want 0", dones);
    end
    collect(basic_cfg(), 100, 0);
    checks++;
    if (timeout || obs_q.size() != 8 || obs_q[0] !== 32'h1000) begin
      errors++; $display("FAIL clear_rerun: got %0d hs first=%h want 8 hs first=00001000", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'hx);
    end
  endtask

  task automatic test_rst_wrap();
    addrgen_ctrl_t c;
    c = basic_cfg();
    c.base_addr = 32'hFFFF_FFF8; c.d0_stride = 32'h8; c.tot_len = 6; c.dim_enable_1h = 2'b00;
    @(negedge clk_i);
    drive_ctrl(c); req_start_i = 1'b1;
    @(negedge clk_i);
    req_start_i = 1'b0; addr_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (addr_valid_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_run: got valid=%b want 1", addr_valid_o);
    end
    rst_ni = 1'b0; addr_ready_i = 1'b0;
    #1;
    checks++;
    if ({ready_start_o, done_o, addr_valid_o} !== 3'b100 || addr_o !== 32'h0) begin
      errors++; $display("FAIL rst_values: got rs/done/valid=%b addr=%h want 100 addr=00000000",
                         {ready_start_o, done_o, addr_valid_o}, addr_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    collect(c, 100, 0);
    checks++;
    if (timeout || obs_q.size() != 6 || obs_q[1] !== 32'h0) begin
      errors++; $display("FAIL rst_wrap: got %0d hs second=%h want 6 hs second=00000000", obs_q.size(), (obs_q.size() > 1) ? obs_q[1] : 32'hx);
    end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      checks++;
      if (obs_q[i] !== model_addr(c, i)) begin
        errors++; $display("FAIL rst_wrap_addr[%0d]: got %h want %h", i, obs_q[i], model_addr(c, i));
      end
    end
  endtask

  task automatic test_random();
    addrgen_ctrl_t c;
    for (int n = 0; n < 10; n++) begin
      c.base_addr = $urandom; c.tot_len = $urandom_range(20, 1);
      c.d0_len = $urandom_range(4); c.d0_stride = $urandom_range(255);
      c.d1_len = $urandom_range(4); c.d1_stride = $urandom;
      c.d2_stride = $urandom; c.dim_enable_1h = 2'($urandom_range(3));
      collect(c, 50, 0);
      checks++;
      if (timeout || obs_q.size() != int'(c.tot_len) || unstable != 0 || done_cyc != last_hs_cyc + 1) begin
        errors++; $display("FAIL rand%0d_stream: got hs=%0d unstable=%0d done=%0d last=%0d want hs=%0d",
                           n, obs_q.size(), unstable, done_cyc, last_hs_cyc, c.tot_len);
      end
      for (int i = 0; i < obs_q.size() && i < int'(c.tot_len); i++) begin
        checks++;
        if (obs_q[i] !== model_addr(c, i)) begin
          errors++; $display("FAIL rand%0d_addr[%0d]: got %h want %h", n, i, obs_q[i], model_addr(c, i));
        end
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_xsrc();
    test_backpressure();
    test_zero_len();
    test_req_ignored();
    test_clear();
    test_rst_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
